bitcount_unit: RTL and testbench
================================

Name: bitcount_unit

Overview:
- Pipelined Zbb bit-count unit for the execute stage. Implements CPOP, CLZ and CTZ on an XLEN-wide operand.
- Uses a valid/ready handshake on both sides, so it absorbs writeback stalls.
- Carries a destination tag alongside each operation.
- A flush input kills all in-flight operations on branch mispredict or trap.

Parameters:
- XLEN, 32, operand width; legal values 32 and 64.
- STAGES, 2, register stages between accept and result; legal values 1 and 2.
- TAG_W, 5, width of the opaque tag (rd index) carried with each operation.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operand and op are presented
- in_ready  output  1  unit can accept this cycle
- in_op  input  2  operation select, bitcnt_op_t
- in_x  input  XLEN  operand
- in_tag  input  TAG_W  tag returned unchanged with the result
- out_valid  output  1  result is presented
- out_ready  input  1  consumer takes the result this cycle
- out_res  output  XLEN  result, zero-extended
- out_tag  output  TAG_W  tag of the presented result

Behaviour:
- Reset (reset_n low, asynchronous):
  - All stage valid bits clear; out_valid=0, out_res=0, out_tag=0.
  - in_ready=1 in the first cycle after release.
- Handshake:
  - Transfer on in_valid&&in_ready (input side) and out_valid&&out_ready (output side).
  - out_res and out_tag hold stable while out_valid&&!out_ready.
- Stage advance: stage k advances when its successor is empty or advancing. in_ready = !v[0] || advance[0], a combinational path from out_ready.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready=1.
- Throughput: 1 op/cycle under no backpressure; no bubbles inserted.
- Op encoding (bitcnt_op_t): CPOP=2'b00, CLZ=2'b01, CTZ=2'b10, 2'b11 reserved.
  - A reserved op is accepted and returns out_res=0 with its tag.
- Stage A (operand conditioning):
  - CPOP: y = x.
  - CTZ: y = ~x & (x - 1).
  - CLZ: y = ~r & (r - 1), where r = bit-reverse(x).
- Stage B (population count):
  - Adder tree over y: 4-bit groups first, then pairwise reduction.
  - Result width is $clog2(XLEN)+1, zero-extended to XLEN.
- Pipeline split:
  - STAGES=2: register after stage A (y, op, tag) and again at the output.
  - STAGES=1: A and B in one cycle, output register only.
- Boundary values:
  - CLZ(0) = CTZ(0) = XLEN.
  - CPOP(all ones) = XLEN.
  - CLZ of a value with MSB set = 0.
  - CTZ of a value with LSB set = 0.
- Flush:
  - On a clk edge with flush=1, all valid bits clear, including a held output.
  - An input presented in the same cycle is dropped.
  - in_ready is forced to 0 during flush.
  - Datapath registers need no clearing.
- Simultaneous events:
  - Accept and output-drain in the same cycle with a full pipe are legal; occupancy is unchanged.
  - flush has priority over both transfers.
- reset_n asserted mid-operation discards all in-flight results; no partial output.

Decomposition:
- Shared package bitcnt_pkg holds:
  - the bitcnt_op_t enum;
  - the function cnt_w(XLEN) = $clog2(XLEN)+1.
- Sub-module popcount_tree (parameter W, combinational) holds the adder tree.
  - Instantiated once in stage B.
  - Reusable by other units.

Test Plan:
- Basic ops, XLEN=32, STAGES=2, out_ready=1:
  - CPOP 0xFFFFFFFF -> 32 on cycle +2.
  - CPOP 0x80000001 -> 2.
  - CLZ 0x00010000 -> 15.
  - CTZ 0x00010000 -> 16.
  - CLZ 0 -> 32; CTZ 0 -> 32.
  - CLZ 0x80000000 -> 0; CTZ 0x00000001 -> 0.
- Back-to-back streaming:
  - 8 consecutive ops with tags 0..7 -> results in order, tags 0..7 on consecutive cycles, in_ready constantly 1.
- Backpressure:
  - Hold out_ready=0 for 4 cycles with in_valid=1 -> pipe fills to STAGES entries, then in_ready=0.
  - out_res and out_tag stay stable throughout.
  - On release, no op is lost or duplicated (scoreboard match).
- Flush:
  - Flush with 2 ops in flight and in_valid=1 -> next cycle out_valid=0, zero results ever emitted for those 3 ops.
  - The following op completes normally with its own tag.
- Reset mid-operation:
  - Drop reset_n with a full pipe -> out_valid=0 immediately (asynchronous), out_res=0.
  - After release, in_ready=1 and the first new op returns its correct result.
- Parameter sweep, XLEN=64, STAGES=1:
  - CPOP 0xFFFFFFFFFFFFFFFF -> 64; CLZ 1 -> 63; CTZ 0 -> 64; latency 1 cycle.
  - Random 10k ops versus a reference model, with random out_ready.

Source files
------------

// File: rtl/bitcount_unit_pkg.sv
// rtl/bitcount_unit_pkg.sv - shared types and helpers for the Zbb bit-count unit
//
// Purpose: operation encoding and result-width helper shared by the bit-count
//          unit, its bus interface and the reusable popcount tree.
// Ports:   none (package).
package bitcnt_pkg;

  typedef enum logic [1:0] {
    OP_CPOP = 2'b00,
    OP_CLZ  = 2'b01,
    OP_CTZ  = 2'b10,
    OP_RSVD = 2'b11
  } bitcnt_op_t;

  // Width of a population count over xlen bits; holds the value xlen itself.
  function automatic int cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/bitcount_unit_if.sv
// rtl/bitcount_unit_if.sv - valid/ready operand and result bus of the bit-count unit
//
// Purpose: groups the request side (in_*) and response side (out_*) handshakes.
// Ports:   master - issuer: drives in_valid/in_op/in_x/in_tag and out_ready,
//                   observes in_ready and out_valid/out_res/out_tag.
//          slave  - the bit-count unit, the mirror image of master.
interface bitcount_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  import bitcnt_pkg::*;

  logic             in_valid;
  logic             in_ready;
  bitcnt_op_t       in_op;
  logic [XLEN-1:0]  in_x;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_res;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );

endinterface

// File: rtl/bitcount_unit_popcount_tree.sv
// rtl/bitcount_unit_popcount_tree.sv - combinational population-count adder tree
//
// Purpose: counts the set bits of din. Bits are first summed in 4-bit groups,
//          then the group counts are reduced pairwise.
// Ports:   din [W-1:0]        operand
//          cnt [$clog2(W):0]  number of set bits in din
module popcount_tree
  import bitcnt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]      din,
  output logic [$clog2(W):0] cnt
);

  localparam int CW = cnt_w(W);
  localparam int G  = (W + 3) / 4;   // number of 4-bit groups
  localparam int WP = G * 4;         // operand padded to whole groups

  logic [WP-1:0] din_p;
  logic [CW-1:0] node [2*G-1];

  assign din_p = WP'(din);

  // Heap-ordered tree: leaves (group counts) at G-1..2G-2, node i sums its
  // children 2i+1 and 2i+2, the root at index 0 is the total.
  always_comb begin
    for (int g = 0; g < G; g++) begin
      node[G-1+g] = CW'(din_p[4*g])   + CW'(din_p[4*g+1]) +
                    CW'(din_p[4*g+2]) + CW'(din_p[4*g+3]);
    end
    for (int i = G - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    cnt = node[0];
  end

endmodule

// File: rtl/bitcount_unit.sv
// rtl/bitcount_unit.sv - pipelined CPOP/CLZ/CTZ unit with valid/ready and flush
//
// Purpose: Zbb bit counts for the execute stage. Stage A conditions the
//          operand so every op reduces to a popcount; stage B is the popcount.
//          STAGES=2 registers after A and at the output, STAGES=1 only at
//          the output. A destination tag travels with each operation.
// Ports:   clk      rising-edge clock
//          reset_n  asynchronous active-low reset
//          flush    synchronous kill of every in-flight operation
//          bus      bitcount_unit_if slave: in_valid/in_ready/in_op/in_x/in_tag
//                   request side, out_valid/out_ready/out_res/out_tag result side
module bitcount_unit
  import bitcnt_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  bitcount_unit_if.slave bus
);

  localparam int CW = cnt_w(XLEN);

  logic [XLEN-1:0]  x_rev;
  logic [XLEN-1:0]  y_comb;
  logic [XLEN-1:0]  pc_in;
  logic [CW-1:0]    pc_cnt;
  logic             in_fire;
  logic             o_load_ok;
  logic             o_v;
  logic [XLEN-1:0]  o_res;
  logic [TAG_W-1:0] o_tag;

  always_comb begin
    x_rev = '0;
    for (int i = 0; i < XLEN; i++) begin
      x_rev[i] = bus.in_x[XLEN-1-i];
    end
  end

  // Stage A: leave exactly the bits to be counted. ~v & (v-1) keeps the run
  // of zeros below the lowest set bit (all ones when v is zero), so CTZ is a
  // popcount of it and CLZ is the same on the reversed operand. A reserved op
  // maps to zero, which yields a zero result with no extra state downstream.
  always_comb begin
    y_comb = '0;
    case (bus.in_op)
      OP_CPOP: y_comb = bus.in_x;
      OP_CLZ:  y_comb = ~x_rev & (x_rev - XLEN'(1));
      OP_CTZ:  y_comb = ~bus.in_x & (bus.in_x - XLEN'(1));
      default: y_comb = '0;
    endcase
  end

  // Stage B
  popcount_tree #(.W(XLEN)) u_popcount_tree (
    .din (pc_in),
    .cnt (pc_cnt)
  );

  // The output register can take new data when empty or being drained.
  assign o_load_ok = !o_v || bus.out_ready;
  assign in_fire   = bus.in_valid && bus.in_ready;

  generate
    if (STAGES == 2) begin : g_two_stage
      logic             a_v;
      logic [XLEN-1:0]  a_y;
      logic [TAG_W-1:0] a_tag;

      assign bus.in_ready = !flush && (!a_v || o_load_ok);
      assign pc_in        = a_y;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_v   <= 1'b0;
          a_y   <= '0;
          a_tag <= '0;
          o_v   <= 1'b0;
          o_res <= '0;
          o_tag <= '0;
        end else if (flush) begin
          a_v <= 1'b0;
          o_v <= 1'b0;
        end else begin
          if (o_load_ok) begin
            o_v <= a_v;
            if (a_v) begin
              o_res <= XLEN'(pc_cnt);
              o_tag <= a_tag;
            end
          end
          if (!a_v || o_load_ok) begin
            a_v <= bus.in_valid;
          end
          if (in_fire) begin
            a_y   <= y_comb;
            a_tag <= bus.in_tag;
          end
        end
      end
    end else begin : g_one_stage
      assign bus.in_ready = !flush && o_load_ok;
      assign pc_in        = y_comb;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          o_v   <= 1'b0;
          o_res <= '0;
          o_tag <= '0;
        end else if (flush) begin
          o_v <= 1'b0;
        end else begin
          if (o_load_ok) begin
            o_v <= bus.in_valid;
          end
          if (in_fire) begin
            o_res <= XLEN'(pc_cnt);
            o_tag <= bus.in_tag;
          end
        end
      end
    end
  endgenerate

  assign bus.out_valid = o_v;
  assign bus.out_res   = o_res;
  assign bus.out_tag   = o_tag;

endmodule

// File: tb/tb_bitcount_unit.sv
// tb/tb_bitcount_unit.sv - self-checking bench for bitcount_unit (32/2 and 64/1)
module tb_bitcount_unit;
  import bitcnt_pkg::*;

  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic reset_n;
  logic flush32;
  logic flush64;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bitcount_unit_if #(.XLEN(32), .TAG_W(5)) bus32 ();
  bitcount_unit_if #(.XLEN(64), .TAG_W(5)) bus64 ();

  bitcount_unit #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_dut32 (
    .clk (clk), .reset_n (reset_n), .flush (flush32), .bus (bus32)
  );
  bitcount_unit #(.XLEN(64), .STAGES(1), .TAG_W(5)) u_dut64 (
    .clk (clk), .reset_n (reset_n), .flush (flush64), .bus (bus64)
  );

  // Reference: count directly from the definition of each operation.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [63:0] x,
                                          input int xlen);
    int n;
    n = 0;
    case (op)
      2'b00: for (int i = 0; i < xlen; i++) if (x[i]) n++;
      2'b01: begin
        n = xlen;
        for (int i = 0; i < xlen; i++) if (x[i]) n = xlen - 1 - i;
      end
      2'b10: begin
        n = xlen;
        for (int i = xlen - 1; i >= 0; i--) if (x[i]) n = i;
      end
      default: n = 0;
    endcase
    return 64'(n);
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'd1 << $urandom_range(0, 63);
      3: return r << $urandom_range(0, 63);
      4: return r >> $urandom_range(0, 63);
      default: return r;
    endcase
  endfunction

  task automatic idle_inputs();
    bus32.in_valid = 1'b0; bus32.in_op = OP_CPOP; bus32.in_x = '0; bus32.in_tag = '0;
    bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_op = OP_CPOP; bus64.in_x = '0; bus64.in_tag = '0;
    bus64.out_ready = 1'b1;
    flush32 = 1'b0;
    flush64 = 1'b0;
  endtask

  task automatic drive32(input logic [1:0] op, input logic [31:0] x, input logic [4:0] tag);
    bus32.in_valid = 1'b1; bus32.in_op = bitcnt_op_t'(op); bus32.in_x = x; bus32.in_tag = tag;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (bus32.out_valid !== 1'b0) $display("FAIL reset_out_valid32 got %b want 0", bus32.out_valid); else passed++;
    checks++; if (bus32.out_res !== 32'd0) $display("FAIL reset_out_res32 got %0h want 0", bus32.out_res); else passed++;
    checks++; if (bus32.out_tag !== 5'd0) $display("FAIL reset_out_tag32 got %0d want 0", bus32.out_tag); else passed++;
    checks++; if (bus32.in_ready !== 1'b1) $display("FAIL reset_in_ready32 got %b want 1", bus32.in_ready); else passed++;
    checks++; if (bus64.out_valid !== 1'b0) $display("FAIL reset_out_valid64 got %b want 0", bus64.out_valid); else passed++;
    checks++; if (bus64.in_ready !== 1'b1) $display("FAIL reset_in_ready64 got %b want 1", bus64.in_ready); else passed++;
  endtask

  logic [1:0]  b_op  [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
  logic [31:0] b_x   [8] = '{32'hFFFFFFFF, 32'h80000001, 32'h00010000, 32'h00010000,
                             32'h0, 32'h0, 32'h80000000, 32'h00000001};
  logic [31:0] b_exp [8] = '{32'd32, 32'd2, 32'd15, 32'd16, 32'd32, 32'd32, 32'd0, 32'd0};

  task automatic test_basic_ops();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive32(b_op[i], b_x[i], 5'(i + 1));
      @(negedge clk);
      bus32.in_valid = 1'b0;
      #1;
      checks++; if (bus32.out_valid !== 1'b0) $display("FAIL basic_latency[%0d] out_valid got %b want 0 at +1", i, bus32.out_valid); else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.out_res !== b_exp[i] || bus32.out_tag !== 5'(i + 1))
        $display("FAIL basic[%0d] got v=%b res=%0d tag=%0d want v=1 res=%0d tag=%0d",
                 i, bus32.out_valid, bus32.out_res, bus32.out_tag, b_exp[i], i + 1);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [8];
    logic [1:0]  op;
    logic [31:0] x;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        op = 2'($urandom_range(0, 3));
        x  = rand_operand()[31:0];
        exp_r[k] = ref_res(op, 64'(x), 32)[31:0];
        drive32(op, x, 5'(k));
      end else begin
        bus32.in_valid = 1'b0;
      end
      #1;
      if (k < 8) begin
        checks++; if (bus32.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b want 1", k, bus32.in_ready); else passed++;
      end
      if (k == 1) begin
        checks++; if (bus32.out_valid !== 1'b0) $display("FAIL b2b_early got out_valid %b want 0", bus32.out_valid); else passed++;
      end
      if (k >= 2) begin
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'(k - 2) || bus32.out_res !== exp_r[k-2])
          $display("FAIL b2b[%0d] got v=%b res=%0d tag=%0d want v=1 res=%0d tag=%0d",
                   k - 2, bus32.out_valid, bus32.out_res, bus32.out_tag, exp_r[k-2], k - 2);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [68:0] q [$];
    logic [68:0] e;
    logic [1:0]  op;
    logic [31:0] x;
    logic [4:0]  tag;
    logic [31:0] p_res;
    logic [4:0]  p_tag;
    logic        held;
    int          sent;
    int          got;
    sent = 0; got = 0; held = 1'b0; p_res = '0; p_tag = '0;
    op = 2'($urandom_range(0, 3)); x = rand_operand()[31:0]; tag = 5'd20;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      if (held) begin
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.out_res !== p_res || bus32.out_tag !== p_tag)
          $display("FAIL bp_stable got v=%b res=%0d tag=%0d want v=1 res=%0d tag=%0d",
                   bus32.out_valid, bus32.out_res, bus32.out_tag, p_res, p_tag);
        else passed++;
      end
      bus32.out_ready = (cyc >= 4);
      if (sent < 6) drive32(op, x, tag); else bus32.in_valid = 1'b0;
      #1;
      if (cyc == 3) begin
        checks++; if (bus32.in_ready !== 1'b0) $display("FAIL bp_full_in_ready got %b want 0", bus32.in_ready); else passed++;
        checks++; if (bus32.out_valid !== 1'b1) $display("FAIL bp_full_out_valid got %b want 1", bus32.out_valid); else passed++;
      end
      held = 1'b0;
      if (bus32.out_valid === 1'b1) begin
        if (bus32.out_ready) begin
          checks++;
          if (q.size() == 0) $display("FAIL bp_extra output res=%0d tag=%0d want none", bus32.out_res, bus32.out_tag);
          else begin
            e = q.pop_front();
            if ({bus32.out_tag, 32'd0, bus32.out_res} !== e)
              $display("FAIL bp_order got res=%0d tag=%0d want res=%0d tag=%0d",
                       bus32.out_res, bus32.out_tag, e[31:0], e[68:64]);
            else passed++;
          end
          got++;
        end else begin
          held = 1'b1; p_res = bus32.out_res; p_tag = bus32.out_tag;
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q.push_back({tag, ref_res(op, 64'(x), 32)});
        sent++;
        op = 2'($urandom_range(0, 3)); x = rand_operand()[31:0]; tag = 5'(20 + sent);
      end
    end
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    checks++; if (got != 6 || q.size() != 0) $display("FAIL bp_count got %0d outputs (%0d left) want 6 (0 left)", got, q.size()); else passed++;
  endtask

  task automatic test_flush();
    int emitted;
    @(negedge clk);
    bus32.out_ready = 1'b0;
    drive32(2'd0, 32'hFFFF0000, 5'd10);
    @(negedge clk);
    drive32(2'd1, 32'h00000100, 5'd11);
    @(negedge clk);
    drive32(2'd2, 32'h00000100, 5'd12);
    bus32.out_ready = 1'b1;
    flush32 = 1'b1;
    #1;
    checks++; if (bus32.in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", bus32.in_ready); else passed++;
    @(negedge clk);
    flush32 = 1'b0;
    bus32.in_valid = 1'b0;
    #1;
    checks++; if (bus32.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", bus32.out_valid); else passed++;
    emitted = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus32.out_valid === 1'b1) emitted++;
    end
    checks++; if (emitted != 0) $display("FAIL flush_killed got %0d outputs want 0", emitted); else passed++;
    @(negedge clk);
    drive32(2'd2, 32'h00010000, 5'd13);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_res !== 32'd16 || bus32.out_tag !== 5'd13)
      $display("FAIL flush_next got v=%b res=%0d tag=%0d want v=1 res=16 tag=13",
               bus32.out_valid, bus32.out_res, bus32.out_tag);
    else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus32.out_ready = 1'b0;
    drive32(2'd0, 32'hFFFFFFFF, 5'd7);
    @(negedge clk);
    drive32(2'd0, 32'h0000000F, 5'd8);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    #1;
    checks++; if (bus32.out_valid !== 1'b1) $display("FAIL rst_mid_full got out_valid %b want 1", bus32.out_valid); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0 || bus32.out_res !== 32'd0 || bus32.out_tag !== 5'd0)
      $display("FAIL rst_mid_async got v=%b res=%0d tag=%0d want v=0 res=0 tag=0",
               bus32.out_valid, bus32.out_res, bus32.out_tag);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus32.out_ready = 1'b1;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", bus32.in_ready); else passed++;
    checks++; if (bus32.out_valid !== 1'b0) $display("FAIL rst_mid_no_out got out_valid %b want 0", bus32.out_valid); else passed++;
    @(negedge clk);
    drive32(2'd1, 32'h00010000, 5'd3);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus32.out_valid !== 1'b1 || bus32.out_res !== 32'd15 || bus32.out_tag !== 5'd3)
      $display("FAIL rst_mid_first got v=%b res=%0d tag=%0d want v=1 res=15 tag=3",
               bus32.out_valid, bus32.out_res, bus32.out_tag);
    else passed++;
  endtask

  logic [1:0]  p_op  [3] = '{2'd0, 2'd1, 2'd2};
  logic [63:0] p_x   [3] = '{64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0};
  logic [63:0] p_exp [3] = '{64'd64, 64'd63, 64'd64};

  task automatic test_param64();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus64.in_valid = 1'b1; bus64.in_op = bitcnt_op_t'(p_op[i]); bus64.in_x = p_x[i];
      bus64.in_tag = 5'(30 - i);
      @(negedge clk);
      bus64.in_valid = 1'b0;
      #1;
      checks++;
      if (bus64.out_valid !== 1'b1 || bus64.out_res !== p_exp[i] || bus64.out_tag !== 5'(30 - i))
        $display("FAIL p64[%0d] got v=%b res=%0d tag=%0d want v=1 res=%0d tag=%0d at +1",
                 i, bus64.out_valid, bus64.out_res, bus64.out_tag, p_exp[i], 30 - i);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [68:0] q32 [$];
    logic [68:0] q64 [$];
    logic [68:0] e;
    logic [1:0]  op32, op64;
    logic [63:0] x32, x64;
    logic [4:0]  t32, t64;
    logic        h32, h64, f32, f64;
    logic [31:0] pr32;
    logic [63:0] pr64;
    logic [4:0]  pt32, pt64;
    int          s32, s64;
    int          cyc;
    s32 = 0; s64 = 0; h32 = 0; h64 = 0; pr32 = '0; pr64 = '0; pt32 = '0; pt64 = '0;
    op32 = 2'($urandom_range(0, 3)); x32 = {32'd0, rand_operand()[31:0]}; t32 = 5'($urandom_range(0, 31));
    op64 = 2'($urandom_range(0, 3)); x64 = rand_operand(); t64 = 5'($urandom_range(0, 31));
    for (cyc = 0; cyc < 60000; cyc++) begin
      if (s32 >= N_RAND && s64 >= N_RAND && q32.size() == 0 && q64.size() == 0) break;
      @(negedge clk);
      if (h32) begin
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.out_res !== pr32 || bus32.out_tag !== pt32)
          $display("FAIL rnd32_stable got v=%b res=%0d tag=%0d want v=1 res=%0d tag=%0d",
                   bus32.out_valid, bus32.out_res, bus32.out_tag, pr32, pt32);
        else passed++;
      end
      if (h64) begin
        checks++;
        if (bus64.out_valid !== 1'b1 || bus64.out_res !== pr64 || bus64.out_tag !== pt64)
          $display("FAIL rnd64_stable got v=%b res=%0d tag=%0d want v=1 res=%0d tag=%0d",
                   bus64.out_valid, bus64.out_res, bus64.out_tag, pr64, pt64);
        else passed++;
      end
      f32 = ($urandom_range(0, 299) == 0);
      f64 = ($urandom_range(0, 299) == 0);
      flush32 = f32;
      flush64 = f64;
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      bus64.out_ready = ($urandom_range(0, 3) != 0);
      bus32.in_valid = (s32 < N_RAND) && ($urandom_range(0, 4) != 0);
      bus32.in_op = bitcnt_op_t'(op32); bus32.in_x = x32[31:0]; bus32.in_tag = t32;
      bus64.in_valid = (s64 < N_RAND) && ($urandom_range(0, 4) != 0);
      bus64.in_op = bitcnt_op_t'(op64); bus64.in_x = x64; bus64.in_tag = t64;
      #1;
      h32 = 1'b0;
      if (f32) begin
        checks++; if (bus32.in_ready !== 1'b0) $display("FAIL rnd32_flush_ready got %b want 0", bus32.in_ready); else passed++;
        q32.delete();
      end else begin
        if (bus32.out_valid === 1'b1) begin
          if (bus32.out_ready) begin
            checks++;
            if (q32.size() == 0) $display("FAIL rnd32_extra output tag=%0d want none", bus32.out_tag);
            else begin
              e = q32.pop_front();
              if ({bus32.out_tag, 32'd0, bus32.out_res} !== e)
                $display("FAIL rnd32 got res=%0d tag=%0d want res=%0d tag=%0d",
                         bus32.out_res, bus32.out_tag, e[63:0], e[68:64]);
              else passed++;
            end
          end else begin
            h32 = 1'b1; pr32 = bus32.out_res; pt32 = bus32.out_tag;
          end
        end
        if (bus32.in_valid && bus32.in_ready) begin
          q32.push_back({t32, ref_res(op32, x32, 32)});
          s32++;
          op32 = 2'($urandom_range(0, 3)); x32 = {32'd0, rand_operand()[31:0]}; t32 = 5'($urandom_range(0, 31));
        end
      end
      h64 = 1'b0;
      if (f64) begin
        checks++; if (bus64.in_ready !== 1'b0) $display("FAIL rnd64_flush_ready got %b want 0", bus64.in_ready); else passed++;
        q64.delete();
      end else begin
        if (bus64.out_valid === 1'b1) begin
          if (bus64.out_ready) begin
            checks++;
            if (q64.size() == 0) $display("FAIL rnd64_extra output tag=%0d want none", bus64.out_tag);
            else begin
              e = q64.pop_front();
              if ({bus64.out_tag, bus64.out_res} !== e)
                $display("FAIL rnd64 got res=%0d tag=%0d want res=%0d tag=%0d",
                         bus64.out_res, bus64.out_tag, e[63:0], e[68:64]);
              else passed++;
            end
          end else begin
            h64 = 1'b1; pr64 = bus64.out_res; pt64 = bus64.out_tag;
          end
        end
        if (bus64.in_valid && bus64.in_ready) begin
          q64.push_back({t64, ref_res(op64, x64, 64)});
          s64++;
          op64 = 2'($urandom_range(0, 3)); x64 = rand_operand(); t64 = 5'($urandom_range(0, 31));
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (s32 < N_RAND || s64 < N_RAND || q32.size() != 0 || q64.size() != 0)
      $display("FAIL rnd_done got sent32=%0d sent64=%0d left32=%0d left64=%0d want %0d %0d 0 0",
               s32, s64, q32.size(), q64.size(), N_RAND, N_RAND);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_param64();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
